spike_code_ctrl: RTL and testbench

Sequencing controller for the 64-bit input code generator in the classification path. It debounces the user key and pulses the generator enable to capture one code word. It then streams that word to the downstream spiking layer as fixed-width chunks over a configurable number of timesteps, using a valid/ready handshake. It sits between the key input, the `code` generator and the first neuron array.

---
 rtl/spike_code_ctrl.sv | 159 +++++++++++++++
 tb/tb_spike_code_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_code_ctrl.sv
// spike_code_ctrl: debounces the user key and pulses the code generator once.
// It then latches the generated code word and streams it downstream as
// CHUNK_W-bit beats, replaying the whole word in each of T_STEPS timesteps.
module spike_code_ctrl #(
  parameter int unsigned CODE_W    = 64,
  parameter int unsigned CHUNK_W   = 8,
  parameter int unsigned T_STEPS   = 4,
  parameter int unsigned DB_CYCLES = 16,
  localparam int unsigned NumChunks = CODE_W / CHUNK_W,
  localparam int unsigned AddrW     = (NumChunks > 1) ? $clog2(NumChunks) : 1,
  localparam int unsigned StepW     = (T_STEPS > 1) ? $clog2(T_STEPS) : 1,
  localparam int unsigned DbW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_state,
  input  logic [CODE_W-1:0]  code_in,
  output logic               code_en,
  output logic [CHUNK_W-1:0] spk_data,
  output logic [AddrW-1:0]   spk_addr,
  output logic               spk_valid,
  input  logic               spk_ready,
  output logic [StepW-1:0]   step_idx,
  output logic               step_last,
  output logic               busy,
  output logic               done
);

  localparam logic [AddrW-1:0] AddrMax = AddrW'(NumChunks - 1);
  localparam logic [StepW-1:0] StepMax = StepW'(T_STEPS - 1);
  localparam logic [DbW-1:0]   DbMax   = DbW'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StLatch,
    StSend,
    StDone
  } state_e;

  state_e             state_q;
  logic [DbW-1:0]     db_cnt_q;
  logic               armed_q;
  logic [CODE_W-1:0]  code_q;

  logic               key_fire;
  logic               addr_wrap;
  logic               step_wrap;
  logic [AddrW-1:0]   addr_nxt;
  logic [CODE_W-1:0]  code_shifted;
  logic [CHUNK_W-1:0] chunk_nxt;

  // Start condition and the next beat's address/chunk, all from registered state.
  always_comb begin
    // The DB_CYCLES-th consecutive high sample while armed launches a sample.
    key_fire     = (state_q == StIdle) && armed_q && key_state && (db_cnt_q == DbMax);
    addr_wrap    = (spk_addr == AddrMax);
    step_wrap    = (step_idx == StepMax);
    addr_nxt     = addr_wrap ? '0 : spk_addr + 1'b1;
    code_shifted = code_q >> (CHUNK_W * 32'(addr_nxt));
    chunk_nxt    = code_shifted[CHUNK_W-1:0];
  end

  // Key debounce and arm bookkeeping; only active while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      armed_q  <= 1'b1;
    end else if (state_q != StIdle) begin
      db_cnt_q <= '0;
    end else if (!key_state) begin
      // A low sample in idle re-arms, so a held key cannot retrigger.
      db_cnt_q <= '0;
      armed_q  <= 1'b1;
    end else if (key_fire) begin
      db_cnt_q <= '0;
      armed_q  <= 1'b0;
    end else if (armed_q) begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  // Code register: written only in LATCH, so later code_in changes never reach the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
    end else if (state_q == StLatch) begin
      code_q <= code_in;
    end
  end

  // Sequencing FSM with all handshake and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      code_en   <= 1'b0;
      spk_data  <= '0;
      spk_addr  <= '0;
      spk_valid <= 1'b0;
      step_idx  <= '0;
      step_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      code_en <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (key_fire) begin
            state_q <= StCapture;
            code_en <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StCapture: begin
          state_q <= StLatch;
        end
        StLatch: begin
          // First beat comes straight from code_in, the same value code_q takes now.
          state_q   <= StSend;
          spk_valid <= 1'b1;
          spk_data  <= code_in[CHUNK_W-1:0];
          spk_addr  <= '0;
          step_idx  <= '0;
          step_last <= (NumChunks == 1);
        end
        StSend: begin
          // Everything holds while the beat is stalled.
          if (spk_ready) begin
            if (addr_wrap && step_wrap) begin
              state_q   <= StDone;
              spk_valid <= 1'b0;
              spk_data  <= '0;
              spk_addr  <= '0;
              step_idx  <= '0;
              step_last <= 1'b0;
              done      <= 1'b1;
            end else begin
              spk_addr  <= addr_nxt;
              spk_data  <= chunk_nxt;
              step_last <= (addr_nxt == AddrMax);
              if (addr_wrap) begin
                step_idx <= step_idx + 1'b1;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_code_ctrl.sv
// Bench for spike_code_ctrl: table-driven directed runs, multi-cycle corner
// sequences, and randomized trials checked against a cycle-plan model.
module tb_spike_code_ctrl;

  localparam int unsigned CODE_W    = 64;
  localparam int unsigned CHUNK_W   = 8;
  localparam int unsigned T_STEPS   = 4;
  localparam int unsigned DB_CYCLES = 16;
  localparam int unsigned NCH       = CODE_W / CHUNK_W;
  localparam int unsigned NBEATS    = NCH * T_STEPS;
  localparam logic [63:0] BASIC     = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_state = 1'b0;
  logic        spk_ready = 1'b0;
  logic [63:0] code_in = '0;
  logic        code_en, spk_valid, step_last, busy, done;
  logic [7:0]  spk_data;
  logic [2:0]  spk_addr;
  logic [1:0]  step_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         stalls;  // ready-low cycles before this beat is accepted (backpressure pass)
    logic [2:0] addr;
    logic [7:0] data;
    logic       last;
  } vec_t;

  vec_t tab[NCH];

  always #5 clk = ~clk;

  spike_code_ctrl #(
    .CODE_W   (CODE_W),
    .CHUNK_W  (CHUNK_W),
    .T_STEPS  (T_STEPS),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_state(key_state),
    .code_in  (code_in),
    .code_en  (code_en),
    .spk_data (spk_data),
    .spk_addr (spk_addr),
    .spk_valid(spk_valid),
    .spk_ready(spk_ready),
    .step_idx (step_idx),
    .step_last(step_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " code_en"}, code_en, 0);
    chk({tag, " spk_valid"}, spk_valid, 0);
    chk({tag, " spk_data"}, spk_data, 0);
    chk({tag, " spk_addr"}, spk_addr, 0);
    chk({tag, " step_idx"}, step_idx, 0);
    chk({tag, " step_last"}, step_last, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk({tag, " back to idle"}, busy, 0);
  endtask

  // Key held high from idle; expects code_en on the DB_CYCLES-th sample.
  task automatic expect_capture(input string tag);
    for (int i = 1; i <= DB_CYCLES; i++) begin
      tick();
      chk({tag, " code_en"}, code_en, (i == DB_CYCLES));
      chk({tag, " busy"}, busy, (i == DB_CYCLES));
    end
  endtask

  // One full sample of BASIC, checked beat by beat against the table.
  task automatic directed_run(input string tag, input bit use_stalls, input bit scramble);
    int ns;
    key_state = 1'b1;
    code_in   = BASIC;
    spk_ready = 1'b1;
    expect_capture(tag);
    tick();
    chk({tag, " latch code_en"}, code_en, 0);
    chk({tag, " latch valid"}, spk_valid, 0);
    chk({tag, " latch busy"}, busy, 1);
    for (int b = 0; b < int'(NBEATS); b++) begin
      ns = use_stalls ? tab[b % NCH].stalls : 0;
      for (int s = 0; s <= ns; s++) begin
        tick();
        if (scramble) code_in = {$urandom, $urandom};
        chk({tag, " valid"}, spk_valid, 1);
        chk({tag, " addr"}, spk_addr, tab[b % NCH].addr);
        chk({tag, " data"}, spk_data, tab[b % NCH].data);
        chk({tag, " step"}, step_idx, b / NCH);
        chk({tag, " last"}, step_last, tab[b % NCH].last);
        chk({tag, " done early"}, done, 0);
        spk_ready = (s == ns);
      end
    end
    tick();
    chk({tag, " done pulse"}, done, 1);
    chk({tag, " done valid"}, spk_valid, 0);
    chk({tag, " done busy"}, busy, 1);
    chk({tag, " done last"}, step_last, 0);
    tick();
    chk({tag, " post done"}, done, 0);
    chk({tag, " post busy"}, busy, 0);
    chk({tag, " post code_en"}, code_en, 0);
    key_state = 1'b0;
    tick();
    tick();
    chk({tag, " stays idle"}, busy, 0);
  endtask

  // Random key bounce, hold and backpressure; expectations come from a cycle plan.
  task automatic rand_trial(input int t);
    bit          kq[$];
    bit          rq[$];
    bit          r;
    logic [63:0] code;
    int          nb, run, dcap, s, acc, last_acc, n, o;
    string       tag;
    tag  = $sformatf("rand%0d", t);
    code = {$urandom, $urandom};
    nb   = $urandom_range(0, 3);
    for (int b = 0; b < nb; b++) begin
      run = $urandom_range(1, DB_CYCLES - 1);
      repeat (run) kq.push_back(1'b1);
      repeat ($urandom_range(1, 3)) kq.push_back(1'b0);
    end
    repeat ($urandom_range(DB_CYCLES, 70)) kq.push_back(1'b1);
    // Drive index at which the DB_CYCLES-th consecutive high is sampled.
    run  = 0;
    dcap = -1;
    for (int i = 0; i < kq.size(); i++) begin
      run = kq[i] ? run + 1 : 0;
      if (run == int'(DB_CYCLES) && dcap < 0) dcap = i;
    end
    // Observation index o sees the outputs after the edge that sampled drive o-1.
    s        = dcap + 3;
    acc      = 0;
    last_acc = -1;
    for (int j = 0; acc < int'(NBEATS); j++) begin
      r = ($urandom_range(0, 2) != 0);
      rq.push_back(r);
      if (j >= s && r) begin
        acc++;
        if (acc == int'(NBEATS)) last_acc = j;
      end
    end
    n = (kq.size() > last_acc + 3) ? kq.size() : last_acc + 3;
    n = n + 2;
    acc = 0;
    for (int d = 0; d < n; d++) begin
      key_state = (d < kq.size()) ? kq[d] : 1'b0;
      spk_ready = (d < rq.size()) ? rq[d] : 1'b1;
      code_in   = (d == dcap + 2) ? code : {$urandom, $urandom};
      tick();
      o = d + 1;
      chk({tag, " code_en"}, code_en, (o == dcap + 1));
      chk({tag, " busy"}, busy, (o >= dcap + 1 && o <= last_acc + 1));
      chk({tag, " done"}, done, (o == last_acc + 1));
      chk({tag, " valid"}, spk_valid, (o >= s && o <= last_acc));
      if (o >= s && o <= last_acc) begin
        chk({tag, " addr"}, spk_addr, acc % NCH);
        chk({tag, " step"}, step_idx, acc / NCH);
        chk({tag, " last"}, step_last, ((acc % NCH) == NCH - 1));
        chk({tag, " data"}, spk_data, (code >> (CHUNK_W * (acc % NCH))) & 64'hFF);
        if (rq[o]) acc++;
      end else begin
        chk({tag, " last idle"}, step_last, 0);
      end
    end
  endtask

  initial begin
    int pulses;
    int n;
    tab[0] = '{0, 3'd0, 8'hEF, 1'b0};
    tab[1] = '{2, 3'd1, 8'hCD, 1'b0};
    tab[2] = '{0, 3'd2, 8'hAB, 1'b0};
    tab[3] = '{2, 3'd3, 8'h89, 1'b0};
    tab[4] = '{0, 3'd4, 8'h67, 1'b0};
    tab[5] = '{2, 3'd5, 8'h45, 1'b0};
    tab[6] = '{0, 3'd6, 8'h23, 1'b0};
    tab[7] = '{2, 3'd7, 8'h01, 1'b1};

    // Reset state.
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_zero("after release");

    directed_run("basic", 1'b0, 1'b0);
    directed_run("backpressure", 1'b1, 1'b0);
    directed_run("isolation", 1'b0, 1'b1);

    // Bounce: 10 high, 1 low, 16 high -> capture on the 16th of the second run.
    spk_ready = 1'b1;
    for (int d = 0; d < 27; d++) begin
      key_state = (d < 10) || (d >= 11);
      tick();
      chk("bounce code_en", code_en, (d == 26));
    end
    wait_idle("bounce");
    key_state = 1'b0;
    tick();

    // Held key: one sample only, then a low + DB_CYCLES highs restarts.
    key_state = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (code_en) pulses++;
    end
    chk("hold pulses", pulses, 1);
    chk("hold idle", busy, 0);
    key_state = 1'b0;
    tick();
    key_state = 1'b1;
    expect_capture("restart");
    wait_idle("restart");
    key_state = 1'b0;
    tick();

    // Reset abort at beat 10.
    key_state = 1'b1;
    spk_ready = 1'b1;
    code_in   = BASIC;
    n = 0;
    while (!spk_valid && n < 40) begin
      tick();
      n++;
    end
    chk("abort reach send", spk_valid, 1);
    repeat (10) tick();
    chk("abort addr", spk_addr, 2);
    chk("abort step", step_idx, 1);
    chk("abort data", spk_data, 8'hAB);
    rst_n = 1'b0;
    #1;
    chk_zero("abort async");
    @(negedge clk);
    rst_n = 1'b1;
    expect_capture("abort rearm");
    wait_idle("abort rearm");
    key_state = 1'b0;
    tick();
    tick();

    for (int t = 0; t < 25; t++) rand_trial(t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
